mem_port_arbiter: RTL

Sequences the single shared memory port between two requesters: the core's load/store/fetch path and a debug/loader master that preloads programs and dumps memory. Accepts one request at a time over a valid/ready handshake, selects between requesters with round-robin priority, drives a registered memory port, waits a fixed read latency and returns one registered response to the owner. Sits between the multicycle core and the unified instruction/data memory. Exports owner and busy status to the per-cycle trace logger.

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 13 +
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// pkg_mem_arbiter: shared types and limits for the memory port arbiter and its clients.
package pkg_mem_arbiter;
    localparam int MAX_MEM_LATENCY = 7;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWNER_CORE, OWNER_DBG} owner_t;
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester that did not own last wins.
module rr_arbiter2
    import pkg_mem_arbiter::*;
(
    input  logic   core_valid,
    input  logic   dbg_valid,
    input  owner_t last_owner,
    output logic   core_gnt,
    output logic   dbg_gnt
);
    assign core_gnt = core_valid & (~dbg_valid | (last_owner == OWNER_DBG));
    assign dbg_gnt  = dbg_valid & ~core_gnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one shared memory port between the core and the debug master,
// issuing one registered access at a time and returning a registered response to its owner.
module mem_port_arbiter
    import pkg_mem_arbiter::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   core_req_valid,
    output logic   core_req_ready,
    input  addr_t  core_req_addr,
    input  data_t  core_req_wdata,
    input  logic   core_req_we,
    input  logic [3:0] core_req_be,
    output logic   core_rsp_valid,
    output data_t  core_rsp_rdata,
    input  logic   dbg_req_valid,
    output logic   dbg_req_ready,
    input  addr_t  dbg_req_addr,
    input  data_t  dbg_req_wdata,
    input  logic   dbg_req_we,
    input  logic [3:0] dbg_req_be,
    output logic   dbg_rsp_valid,
    output data_t  dbg_rsp_rdata,
    output logic   mem_en,
    output logic   mem_we,
    output addr_t  mem_addr,
    output data_t  mem_wdata,
    output logic [3:0] mem_be,
    input  data_t  mem_rdata,
    output logic   busy,
    output owner_t owner
);
    localparam int CW = $clog2(MAX_MEM_LATENCY + 1);
    state_t state;
    owner_t last_owner;
    logic [CW-1:0] lat_cnt;
    logic is_wr;
    logic core_gnt, dbg_gnt;
    rr_arbiter2 u_rr (
        .core_valid(core_req_valid),
        .dbg_valid (dbg_req_valid),
        .last_owner(last_owner),
        .core_gnt  (core_gnt),
        .dbg_gnt   (dbg_gnt)
    );
    assign core_req_ready = (state == IDLE) & core_gnt;
    assign dbg_req_ready  = (state == IDLE) & dbg_gnt;
    assign busy           = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            owner          <= OWNER_DBG;
            last_owner     <= OWNER_DBG;
            is_wr          <= 1'b0;
            core_rsp_valid <= 1'b0;
            core_rsp_rdata <= '0;
            dbg_rsp_valid  <= 1'b0;
            dbg_rsp_rdata  <= '0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_be         <= '0;
        end else begin
            core_rsp_valid <= 1'b0;
            dbg_rsp_valid  <= 1'b0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            case (state)
                IDLE: if (core_req_ready | dbg_req_ready) begin
                    mem_en     <= 1'b1;
                    mem_we     <= core_req_ready ? core_req_we : dbg_req_we;
                    is_wr      <= core_req_ready ? core_req_we : dbg_req_we;
                    mem_addr   <= core_req_ready ? core_req_addr : dbg_req_addr;
                    mem_wdata  <= core_req_ready ? core_req_wdata : dbg_req_wdata;
                    mem_be     <= core_req_ready ? core_req_be : dbg_req_be;
                    owner      <= core_req_ready ? OWNER_CORE : OWNER_DBG;
                    last_owner <= core_req_ready ? OWNER_CORE : OWNER_DBG;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    lat_cnt <= CW'(MEM_LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: if (lat_cnt == '0) begin
                    // writes still answer, but with zero data
                    core_rsp_valid <= owner == OWNER_CORE;
                    dbg_rsp_valid  <= owner == OWNER_DBG;
                    if (owner == OWNER_CORE) core_rsp_rdata <= is_wr ? '0 : mem_rdata;
                    else dbg_rsp_rdata <= is_wr ? '0 : mem_rdata;
                    state <= IDLE;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
